// File: rtl/aes_byte_seq.sv
// aes_byte_seq: byte-stream front end for the byte-serial AES core aestop.
// Turns a command + valid/ready byte stream into loadkey/load_shift/staenc/
// stadec/din sequencing, then unloads the 16-byte result through a
// valid/ready output register with back-pressure.
// Optional: define AES_KEY_CHK_EN to add the err output and key-loaded check.
module aes_byte_seq #(
  parameter int unsigned CORE_LAT  = 13,
  parameter int unsigned BLK_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       aes_loadkey,
  output logic       aes_load_shift,
  output logic       aes_staenc,
  output logic       aes_stadec,
  output logic [7:0] aes_din,
  input  logic [7:0] aes_dout
`ifdef AES_KEY_CHK_EN
  ,
  output logic       err
`endif
);

  localparam int unsigned CNT_W  = $clog2(BLK_BYTES);
  localparam int unsigned WAIT_W = $clog2(CORE_LAT + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLK_BYTES - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(CORE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_DATA,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  typedef enum logic [1:0] {
    OP_KEY  = 2'b00,
    OP_ENC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
`ifdef AES_KEY_CHK_EN
  logic              key_loaded_q, key_loaded_d;
  logic              err_q, err_d;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef AES_KEY_CHK_EN
  assign err       = err_q;
`endif

  // Next-state, core strobes and out-register control.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    byte_cnt_d     = byte_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    in_ready       = 1'b0;
    aes_loadkey    = 1'b0;
    aes_load_shift = 1'b0;
    aes_staenc     = 1'b0;
    aes_stadec     = 1'b0;
    aes_din        = '0;
`ifdef AES_KEY_CHK_EN
    key_loaded_d   = key_loaded_q;
    err_d          = 1'b0;
`endif

    // Drain runs in every state; a capture in UNLOAD below overrides it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = op_t'(cmd_op);
          byte_cnt_d = '0;
          case (op_t'(cmd_op))
            OP_KEY: state_d = S_LOAD_KEY;
            OP_ENC, OP_DEC: begin
`ifdef AES_KEY_CHK_EN
              if (!key_loaded_q) begin
                err_d = 1'b1;
              end else begin
                state_d = S_LOAD_DATA;
              end
`else
              state_d = S_LOAD_DATA;
`endif
            end
            default: begin
`ifdef AES_KEY_CHK_EN
              err_d = 1'b1;
`endif
            end
          endcase
        end
      end

      S_LOAD_KEY, S_LOAD_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          aes_din = in_data;
          if (state_q == S_LOAD_KEY) begin
            aes_loadkey = 1'b1;
          end else begin
            aes_load_shift = 1'b1;
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (state_q == S_LOAD_KEY) begin
              state_d = S_IDLE;
`ifdef AES_KEY_CHK_EN
              key_loaded_d = 1'b1;
`endif
            end else begin
              state_d = S_START;
            end
          end
        end
      end

      S_START: begin
        aes_staenc = (op_q == OP_ENC);
        aes_stadec = (op_q == OP_DEC);
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          byte_cnt_d = '0;
          state_d    = S_UNLOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_UNLOAD: begin
        // Core only advances when the captured byte has somewhere to go.
        if (!out_valid_q || out_ready) begin
          out_data_d     = aes_dout;
          out_valid_d    = 1'b1;
          aes_load_shift = 1'b1;
          byte_cnt_d     = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and out register, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_KEY;
      byte_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
`ifdef AES_KEY_CHK_EN
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      byte_cnt_q   <= byte_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
`ifdef AES_KEY_CHK_EN
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_byte_seq.sv
// Self-checking bench for aes_byte_seq with a behavioural byte-serial core
// model driving aes_dout. Build with AES_KEY_CHK_EN to exercise err.
module tb_aes_byte_seq;

  localparam int CORE_LAT = 13;

  function automatic logic [127:0] rev16(input logic [127:0] be);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = be[8*(15-i) +: 8];
    return r;
  endfunction

  // Byte i of a block lives at [8*i +: 8].
  localparam logic [127:0] K_AES = rev16(128'h72AE2CD63D6C4AE1678418BE48230029);
  localparam logic [127:0] P_AES = rev16(128'h01EB26E941BB5AF16DF116495F906952);
  localparam logic [127:0] C_AES = rev16(128'h2E760910D58788244791356DF43E041D);

  // Known AES vector, otherwise an invertible toy cipher standing in for AES.
  function automatic logic [127:0] cipher(input int op, input logic [127:0] key,
                                          input logic [127:0] blk);
    logic [127:0] x, r;
    if (op == 1 && key == K_AES && blk == P_AES) return C_AES;
    if (op == 2 && key == K_AES && blk == C_AES) return P_AES;
    x = '0;
    r = '0;
    if (op == 1) begin
      for (int j = 0; j < 16; j++) x[8*j +: 8] = blk[8*j +: 8] ^ key[8*j +: 8] ^ 8'(32'h5A + j);
      for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*((5*i)%16) +: 8];
    end else begin
      for (int i = 0; i < 16; i++) x[8*((5*i)%16) +: 8] = blk[8*i +: 8];
      for (int j = 0; j < 16; j++) r[8*j +: 8] = x[8*j +: 8] ^ key[8*j +: 8] ^ 8'(32'h5A + j);
    end
    return r;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       aes_loadkey;
  logic       aes_load_shift;
  logic       aes_staenc;
  logic       aes_stadec;
  logic [7:0] aes_din;
  logic [7:0] aes_dout;
`ifdef AES_KEY_CHK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  aes_byte_seq #(.CORE_LAT(CORE_LAT), .BLK_BYTES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy),
    .aes_loadkey(aes_loadkey), .aes_load_shift(aes_load_shift),
    .aes_staenc(aes_staenc), .aes_stadec(aes_stadec),
    .aes_din(aes_din), .aes_dout(aes_dout)
`ifdef AES_KEY_CHK_EN
    , .err(err)
`endif
  );

  // Core model: key and data shift registers, result appears CORE_LAT
  // cycles after the start pulse; garbage is visible until then.
  logic [127:0] core_key, core_buf, core_in;
  int           core_lat, core_op;

  always @(posedge clk) begin
    if (rst) begin
      core_key <= '0;
      core_buf <= '0;
      core_in  <= '0;
      core_lat <= 0;
      core_op  <= 0;
    end else begin
      if (aes_loadkey) core_key <= {aes_din, core_key[127:8]};
      if (aes_load_shift) core_buf <= {aes_din, core_buf[127:8]};
      if (aes_staenc || aes_stadec) begin
        core_lat <= CORE_LAT;
        core_op  <= aes_staenc ? 1 : 2;
        core_in  <= core_buf;
        core_buf <= {8{16'hDEAD}};
      end else if (core_lat != 0) begin
        core_lat <= core_lat - 1;
        if (core_lat == 1) core_buf <= cipher(core_op, core_key, core_in);
      end
    end
  end

  assign aes_dout = core_buf[7:0];

  int           checks = 0;
  int           errors = 0;
  int           lk_cnt = 0, ls_cnt = 0, st_cnt = 0, sd_cnt = 0;
  logic [7:0]   got_q[$];
  logic [127:0] ref_key;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol checks, sampled mid-cycle.
  task automatic monitor();
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (aes_loadkey) lk_cnt++;
      if (aes_load_shift) ls_cnt++;
      if (aes_staenc) st_cnt++;
      if (aes_stadec) sd_cnt++;
      chk("ctrl_onehot",
          ($countones({aes_loadkey, aes_load_shift, aes_staenc, aes_stadec}) <= 1), 1'b1);
      chk("cmd_ready_vs_busy", cmd_ready, !busy);
      if (in_ready) begin
        chk("din_pass", aes_din, in_valid ? in_data : 8'h00);
        chk("load_strobe", aes_loadkey | aes_load_shift, in_valid);
      end else begin
        chk("din_idle", aes_din, 8'h00);
        chk("loadkey_idle", aes_loadkey, 1'b0);
      end
      if (out_valid && !out_ready && !in_ready) chk("shift_while_full", aes_load_shift, 1'b0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    chk("cmd_ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic load_blk(input logic [127:0] blk, input int gap_pct);
    for (int i = 0; i < 16; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      chk("in_ready_in_load", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = blk[8*i +: 8];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // rdy: 0 always ready, 1 toggling 1010..., 2 random.
  task automatic collect(input int rdy, input int stop_at, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (got_q.size() < stop_at && n < 400) begin
      if (lat < 0 && out_valid) lat = n;
      case (rdy)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      tick();
      n++;
    end
    chk("out_byte_count", got_q.size(), stop_at);
  endtask

  function automatic logic [127:0] q2blk();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < got_q.size()) r[8*i +: 8] = got_q[i];
    return r;
  endfunction

  task automatic run_block(input logic [1:0] op, input logic [127:0] blk,
                           input logic [127:0] exp, input int gap, input int rdy);
    int st0, sd0, lat;
    got_q.delete();
    st0 = st_cnt;
    sd0 = sd_cnt;
    send_cmd(op);
    chk("busy_after_cmd", busy, 1'b1);
    load_blk(blk, gap);
    collect(rdy, 16, lat);
    chk("first_out_latency", lat, 15);
    chk("staenc_pulses", st_cnt - st0, (op == 2'b01) ? 1 : 0);
    chk("stadec_pulses", sd_cnt - sd0, (op == 2'b10) ? 1 : 0);
    chk("result_block", q2blk(), exp);
    out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] b1, b2, e1, e2;
    int           lat, n;
    int           lk0, ls0, st0, sd0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    ref_key = '0;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_aes_ctrl", {aes_loadkey, aes_load_shift, aes_staenc, aes_stadec}, 4'b0000);
    rst = 1'b0;

    // Key load with in_valid held.
    lk_cnt = 0;
    send_cmd(2'b00);
    chk("busy_in_key_load", busy, 1'b1);
    load_blk(K_AES, 0);
    chk("busy_after_key", busy, 1'b0);
    chk("loadkey_cycles", lk_cnt, 16);
    ref_key = K_AES;

    // Known-vector encrypt, then decrypt with gaps and toggling out_ready.
    run_block(2'b01, P_AES, C_AES, 0, 0);
    run_block(2'b10, C_AES, P_AES, 35, 1);

    // Back-to-back encrypts; second command taken while last byte pends.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    b2 = {$urandom, $urandom, $urandom, $urandom};
    e1 = cipher(1, ref_key, b1);
    e2 = cipher(1, ref_key, b2);
    got_q.delete();
    send_cmd(2'b01);
    load_blk(b1, 0);
    collect(0, 15, lat);
    chk("b2b_first_latency", lat, 15);
    out_ready = 1'b0;
    chk("b2b_last_pending", out_valid, 1'b1);
    chk("b2b_idle_with_pending", cmd_ready, 1'b1);
    send_cmd(2'b01);
    chk("b2b_pending_held", out_valid, 1'b1);
    chk("b2b_pending_data", out_data, e1[127:120]);
    out_ready = 1'b1;
    load_blk(b2, 0);
    chk("b2b_block1", q2blk(), e1);
    got_q.delete();
    collect(2, 16, lat);
    chk("b2b_second_latency", lat, 15);
    chk("b2b_block2", q2blk(), e2);
    out_ready = 1'b0;

    // Random blocks, with an occasional key reload.
    for (int r = 0; r < 5; r++) begin
      logic [1:0]   op;
      logic [127:0] blk;
      if (r == 2) begin
        ref_key = {$urandom, $urandom, $urandom, $urandom};
        lk_cnt  = 0;
        send_cmd(2'b00);
        load_blk(ref_key, 30);
        chk("reload_loadkey_cycles", lk_cnt, 16);
      end
      op  = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_block(op, blk, cipher(int'(op), ref_key, blk), 30, 2);
    end

    // Reserved op: no core activity, stays idle.
    lk0 = lk_cnt; ls0 = ls_cnt; st0 = st_cnt; sd0 = sd_cnt;
    send_cmd(2'b11);
    chk("rsvd_idle", cmd_ready, 1'b1);
`ifdef AES_KEY_CHK_EN
    chk("rsvd_err", err, 1'b1);
`endif
    tick();
`ifdef AES_KEY_CHK_EN
    chk("rsvd_err_pulse", err, 1'b0);
`endif
    chk("rsvd_no_activity", {lk_cnt - lk0, ls_cnt - ls0, st_cnt - st0, sd_cnt - sd0}, 128'd0);

    // Reset in the middle of UNLOAD with the out register stuck full.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    send_cmd(2'b01);
    load_blk(b1, 0);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("reached_unload", out_valid, 1'b1);
    tick(); tick();
    chk("unload_stalled", busy, 1'b1);
    rst = 1'b1;
    tick(); tick();
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_aes_ctrl", {aes_loadkey, aes_load_shift, aes_staenc, aes_stadec}, 4'b0000);
    chk("midrst_aes_din", aes_din, 8'h00);
    rst = 1'b0;
    got_q.delete();
    ref_key = '0;

`ifdef AES_KEY_CHK_EN
    // Encrypt without a key: err pulse, no core activity.
    lk0 = lk_cnt; ls0 = ls_cnt; st0 = st_cnt; sd0 = sd_cnt;
    chk("nokey_err_low", err, 1'b0);
    send_cmd(2'b01);
    chk("nokey_err", err, 1'b1);
    chk("nokey_cmd_ready", cmd_ready, 1'b1);
    chk("nokey_busy", busy, 1'b0);
    tick();
    chk("nokey_err_pulse", err, 1'b0);
    chk("nokey_no_activity", {lk_cnt - lk0, ls_cnt - ls0, st_cnt - st0, sd_cnt - sd0}, 128'd0);
`else
    // Without the check, encrypt runs against the core's cleared key.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    run_block(2'b01, b1, cipher(1, '0, b1), 20, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
